pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble/flush controller: tracks per-port memory service within a
// pipeline step, drives per-register load enables and valid bits, counts stalls.
module pipe_stall_ctrl #(
  parameter int STAGES      = 5,
  parameter int PORTS       = 2,
  parameter int HAZ_STAGE   = 1,
  parameter int FLUSH_STAGE = 3,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORTS-1:0]   need,
  input  logic [PORTS-1:0]   resp,
  output logic [PORTS-1:0]   port_req,
  input  logic               hazard,
  input  logic               flush,
  input  logic               clr_cnt,
  output logic               advance,
  output logic [STAGES-1:0]  stage_load,
  output logic [STAGES-1:0]  stage_valid,
  output logic [CNT_W-1:0]   stall_cnt
);

  if (HAZ_STAGE < 0 || HAZ_STAGE > STAGES - 2) begin : g_bad_haz_stage
    $error("pipe_stall_ctrl: HAZ_STAGE out of range");
  end
  if (FLUSH_STAGE < 0 || FLUSH_STAGE > STAGES - 2) begin : g_bad_flush_stage
    $error("pipe_stall_ctrl: FLUSH_STAGE out of range");
  end

  logic [PORTS-1:0]  done;
  logic [PORTS-1:0]  done_nxt;
  logic [PORTS-1:0]  port_ok;
  logic [STAGES-1:0] valid_nxt;
  logic              hazard_eff;
  logic              cnt_inc;

  // A port is satisfied if it is idle, already serviced, or answering right now.
  assign port_ok    = ~need | done | resp;
  assign advance    = &port_ok;
  assign port_req   = need & ~done;
  assign hazard_eff = hazard & ~flush;
  assign cnt_inc    = ~advance | hazard_eff;

  always_comb begin
    done_nxt = '0;
    if (!advance) begin
      done_nxt = done | (need & resp);
    end
  end

  always_comb begin
    stage_load = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_load[i] = advance & ~(hazard_eff & (i <= HAZ_STAGE));
    end
  end

  // Flush wins over hazard; the hazard case holds the front and inserts a bubble.
  always_comb begin
    valid_nxt = stage_valid;
    if (advance) begin
      valid_nxt[0] = 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        valid_nxt[i] = stage_valid[i-1];
      end
      if (flush) begin
        for (int i = 1; i <= FLUSH_STAGE + 1; i++) begin
          valid_nxt[i] = 1'b0;
        end
      end else if (hazard) begin
        for (int i = 0; i <= HAZ_STAGE; i++) begin
          valid_nxt[i] = stage_valid[i];
        end
        valid_nxt[HAZ_STAGE+1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= '0;
      stage_valid <= STAGES'(1);
    end else begin
      done        <= done_nxt;
      stage_valid <= valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (cnt_inc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed, table-driven bench for pipe_stall_ctrl (5 stages, 2 ports, 4-bit
// counter) plus hand sequences for counter saturation and asynchronous reset.
module tb_pipe_stall_ctrl;

  localparam int STAGES = 5;
  localparam int PORTS  = 2;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [PORTS-1:0]  need;
  logic [PORTS-1:0]  resp;
  logic [PORTS-1:0]  port_req;
  logic              hazard;
  logic              flush;
  logic              clr_cnt;
  logic              advance;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(
    .STAGES(STAGES), .PORTS(PORTS), .HAZ_STAGE(1), .FLUSH_STAGE(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .need(need), .resp(resp), .port_req(port_req),
    .hazard(hazard), .flush(flush), .clr_cnt(clr_cnt), .advance(advance),
    .stage_load(stage_load), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] need;
    logic [1:0] resp;
    logic       hazard;
    logic       flush;
    logic       clr;
    logic [1:0] exp_req;
    logic       exp_adv;
    logic [4:0] exp_load;
    logic [4:0] exp_valid;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic addVec(input logic [1:0] n, input logic [1:0] r, input logic h,
                        input logic f, input logic c, input logic [1:0] ereq,
                        input logic eadv, input logic [4:0] eload,
                        input logic [4:0] evalid, input logic [3:0] ecnt);
    vec_t v;
    v.need = n; v.resp = r; v.hazard = h; v.flush = f; v.clr = c;
    v.exp_req = ereq; v.exp_adv = eadv; v.exp_load = eload;
    v.exp_valid = evalid; v.exp_cnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] n, input logic [1:0] r,
                               input logic h, input logic f, input logic c);
    need = n; resp = r; hazard = h; flush = f; clr_cnt = c;
  endtask

  initial begin
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 16'(stage_valid), 16'h01);
    checkOutput("reset_cnt", 16'(stall_cnt), 16'h0);
    checkOutput("reset_req", 16'(port_req), 16'h0);
    checkOutput("reset_adv", 16'(advance), 16'h1);
    rst_n = 1'b1;

    //      need   resp   hz    fl    clr   req    adv   load      valid_after cnt_after
    addVec(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'b11111, 5'b00011, 4'd0);
    addVec(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'b11111, 5'b00111, 4'd0);
    addVec(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'b11111, 5'b01111, 4'd0);
    addVec(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'b11111, 5'b11111, 4'd0);
    addVec(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'b11111, 5'b11111, 4'd0);
    addVec(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 5'b11100, 5'b11011, 4'd1);
    addVec(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 5'b00000, 5'b11011, 4'd2);
    addVec(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'b00000, 5'b11011, 4'd3);
    addVec(2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'b11111, 5'b10111, 4'd3);
    addVec(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 5'b11111, 5'b01111, 4'd3);
    addVec(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 5'b00000, 5'b01111, 4'd4);
    addVec(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 5'b11100, 5'b11011, 4'd5);
    addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 5'b11111, 5'b10111, 4'd0);
    addVec(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 5'b11111, 5'b00001, 4'd0);
    addVec(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'b00000, 5'b00001, 4'd1);
    addVec(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 5'b00000, 5'b00001, 4'd2);
    addVec(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'b00000, 5'b00001, 4'd3);
    addVec(2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'b11111, 5'b00011, 4'd3);
    addVec(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 5'b00000, 5'b00011, 4'd4);
    addVec(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 5'b11111, 5'b00111, 4'd4);
    addVec(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 5'b11111, 5'b01111, 4'd0);

    @(negedge clk);
    foreach (vq[i]) begin
      applyStimulus(vq[i].need, vq[i].resp, vq[i].hazard, vq[i].flush, vq[i].clr);
      #1;
      checkOutput($sformatf("v%0d_req", i), 16'(port_req), 16'(vq[i].exp_req));
      checkOutput($sformatf("v%0d_adv", i), 16'(advance), 16'(vq[i].exp_adv));
      checkOutput($sformatf("v%0d_load", i), 16'(stage_load), 16'(vq[i].exp_load));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_valid", i), 16'(stage_valid), 16'(vq[i].exp_valid));
      checkOutput($sformatf("v%0d_cnt", i), 16'(stall_cnt), 16'(vq[i].exp_cnt));
    end

    // Counter saturation: 2^4+3 stalled cycles from zero, then clear mid-stall.
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    checkOutput("sat_cnt", 16'(stall_cnt), 16'hF);
    checkOutput("sat_valid_hold", 16'(stage_valid), 16'h0F);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("clr_in_stall", 16'(stall_cnt), 16'h0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("cnt_after_clr", 16'(stall_cnt), 16'h1);

    // Asynchronous reset while port 0 is already serviced in a stalled step.
    applyStimulus(2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("pre_rst_req", 16'(port_req), 16'h2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", 16'(port_req), 16'h3);
    checkOutput("async_rst_valid", 16'(stage_valid), 16'h01);
    checkOutput("async_rst_cnt", 16'(stall_cnt), 16'h0);
    checkOutput("async_rst_adv", 16'(advance), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
